// File: rtl/tree_loader_if.sv
// Node stream in, sideband field writes and status out, between the upstream
// producer (master) and the loader (slave).
interface tree_loader_if #(
   parameter int NODE_SIZE        = 32,
   parameter int W_ADDR           = 10,
   parameter int MAX_DATA_WIDTH   = 12,
   parameter int MAX_CONFIG_WIDTH = 10
);
   logic                        in_valid;
   logic                        in_ready;
   logic [NODE_SIZE-1:0]        in_node;
   logic                        in_last;
   logic                        mem_par;
   logic                        mem_act;
   logic                        mem_rew;
   logic                        mem_weight;
   logic [W_ADDR-1:0]           mem_addr;
   logic [MAX_DATA_WIDTH-1:0]   mem_data;
   logic                        conf_nodes;
   logic [MAX_CONFIG_WIDTH-1:0] conf_data;
   logic                        busy;
   logic                        overflow_err;

   modport master (
      output in_valid, in_node, in_last,
      input  in_ready, mem_par, mem_act, mem_rew, mem_weight, mem_addr, mem_data,
             conf_nodes, conf_data, busy, overflow_err
   );

   modport slave (
      input  in_valid, in_node, in_last,
      output in_ready, mem_par, mem_act, mem_rew, mem_weight, mem_addr, mem_data,
             conf_nodes, conf_data, busy, overflow_err
   );
endinterface

// File: rtl/tree_loader.sv
// Buffers packed node words and serialises each into four field writes,
// closing every frame with a config write carrying its node count.
module tree_loader #(
   parameter int NODE_SIZE        = 32,
   parameter int W_ADDR           = 10,
   parameter int MAX_DATA_WIDTH   = 12,
   parameter int MAX_CONFIG_WIDTH = 10,
   parameter int FIFO_DEPTH       = 4
) (
   input logic         clk,
   input logic         rst,
   tree_loader_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PAR  = 3'd1;
   localparam logic [2:0] S_ACT  = 3'd2;
   localparam logic [2:0] S_REW  = 3'd3;
   localparam logic [2:0] S_WGT  = 3'd4;
   localparam logic [2:0] S_CONF = 3'd5;

   localparam logic [W_ADDR-1:0] CNT_MAX = '1;

   logic [NODE_SIZE-1:0]  fifo_mem [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last_q;
   logic [AW:0]           wr_ptr_q, rd_ptr_q;
   logic [AW-1:0]         wr_idx, rd_idx;
   logic                  fifo_full, fifo_empty, push, pop;

   logic [2:0]            state_q, state_d;
   logic [W_ADDR-1:0]     cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic [NODE_SIZE-1:0]  hold_node_q;
   logic                  hold_last_q;

   assign wr_idx     = wr_ptr_q[AW-1:0];
   assign rd_idx     = rd_ptr_q[AW-1:0];
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

   assign bus.in_ready = !rst && !fifo_full;
   assign push         = bus.in_valid && bus.in_ready;

   // Node payload lives in RAM and is read synchronously into the holding register.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_idx] <= bus.in_node;
      if (pop)  hold_node_q      <= fifo_mem[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         hold_last_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q            <= wr_ptr_q + 1'b1;
            fifo_last_q[wr_idx] <= bus.in_last;
         end
         if (pop) begin
            rd_ptr_q    <= rd_ptr_q + 1'b1;
            hold_last_q <= fifo_last_q[rd_idx];
         end
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: pop = !fifo_empty;
         S_PAR:  state_d = S_ACT;
         S_ACT:  state_d = S_REW;
         S_REW:  state_d = S_WGT;
         S_WGT: begin
            cnt_d = cnt_q + 1'b1;
            if (hold_last_q) state_d = S_CONF;
            else if (fifo_empty) state_d = S_IDLE;
            else pop = 1'b1;
         end
         S_CONF: begin
            cnt_d = '0;
            if (fifo_empty) state_d = S_IDLE;
            else pop = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      // cnt_d is the index the popped word would take; the last index is reserved.
      if (pop) begin
         if (cnt_d == CNT_MAX) begin
            ovf_d   = 1'b1;
            state_d = fifo_last_q[rd_idx] ? S_CONF : S_IDLE;
         end else begin
            state_d = S_PAR;
         end
      end
   end

   always_comb begin
      bus.mem_par    = 1'b0;
      bus.mem_act    = 1'b0;
      bus.mem_rew    = 1'b0;
      bus.mem_weight = 1'b0;
      bus.conf_nodes = 1'b0;
      bus.mem_data   = '0;
      bus.conf_data  = '0;
      bus.mem_addr   = cnt_q;
      case (state_q)
         S_PAR: begin
            bus.mem_par  = 1'b1;
            bus.mem_data = MAX_DATA_WIDTH'(hold_node_q[31:22]);
         end
         S_ACT: begin
            bus.mem_act  = 1'b1;
            bus.mem_data = MAX_DATA_WIDTH'(hold_node_q[21:19]);
         end
         S_REW: begin
            bus.mem_rew  = 1'b1;
            bus.mem_data = MAX_DATA_WIDTH'(hold_node_q[18:7]);
         end
         S_WGT: begin
            bus.mem_weight = 1'b1;
            bus.mem_data   = MAX_DATA_WIDTH'(hold_node_q[6:0]);
         end
         S_CONF: begin
            bus.conf_nodes = 1'b1;
            bus.conf_data  = MAX_CONFIG_WIDTH'(cnt_q);
         end
         default: ;
      endcase
   end

   assign bus.busy         = !fifo_empty || (state_q != S_IDLE);
   assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_tree_loader.sv
// Directed bench for tree_loader: records every strobe cycle and compares the
// write sequence and its timing against hand-built expectations.
module tb_tree_loader;
   typedef struct {
      int cyc;
      int kind;   // 0 par, 1 act, 2 rew, 3 wgt, 4 conf, 9 several strobes
      int addr;
      int data;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc_cnt = 0;
   int   checks = 0;
   int   errors = 0;
   int   accepted = 0;
   int   stall_seen = 0;
   int   stall_at = -1;
   int   acc_edge = 0;
   int   idle_cyc = 0;
   ev_t  obs_q[$];
   ev_t  exp_q[$];
   logic [4:0] mon_s;
   ev_t  mon_ev;
   logic [31:0] w0, w1, w2;

   tree_loader_if bus ();

   tree_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk) begin
      if (!rst) begin
         mon_s = {bus.conf_nodes, bus.mem_weight, bus.mem_rew, bus.mem_act, bus.mem_par};
         if (|mon_s) begin
            mon_ev.cyc  = cyc_cnt;
            mon_ev.kind = ($countones(mon_s) != 1) ? 9 :
                          mon_s[0] ? 0 : mon_s[1] ? 1 : mon_s[2] ? 2 : mon_s[3] ? 3 : 4;
            mon_ev.addr = mon_s[4] ? -1 : int'(bus.mem_addr);
            mon_ev.data = mon_s[4] ? int'(bus.conf_data) : int'(bus.mem_data);
            obs_q.push_back(mon_ev);
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input int i);
      logic [31:0] t, r;
      t = i;
      r = i * 37;
      return {t[9:0], t[2:0], r[11:0], t[6:0]};
   endfunction

   task automatic exp_node(input int addr, input logic [31:0] w);
      exp_q.push_back('{0, 0, addr, int'(w[31:22])});
      exp_q.push_back('{0, 1, addr, int'(w[21:19])});
      exp_q.push_back('{0, 2, addr, int'(w[18:7])});
      exp_q.push_back('{0, 3, addr, int'(w[6:0])});
   endtask

   task automatic exp_conf(input int n);
      exp_q.push_back('{0, 4, -1, n});
   endtask

   // Entered and left at a negedge; the transfer happens on the posedge between.
   task automatic push(input logic [31:0] w, input logic l);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_node  = w;
      bus.in_last  = l;
      if (!bus.in_ready && stall_seen == 0) begin
         stall_seen = 1;
         stall_at   = accepted;
      end
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("push.ready_timeout", bus.in_ready, 1);
      acc_edge = cyc_cnt + 1;
      accepted++;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (bus.busy && n < 6000) begin
         @(negedge clk);
         n++;
      end
      check({name, ".idle"}, bus.busy, 0);
      idle_cyc = cyc_cnt;
   endtask

   task automatic compare_events(input string name);
      check({name, ".count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check($sformatf("%s[%0d].kind", name, i), obs_q[i].kind, exp_q[i].kind);
         if (exp_q[i].kind != 4)
            check($sformatf("%s[%0d].addr", name, i), obs_q[i].addr, exp_q[i].addr);
         check($sformatf("%s[%0d].data", name, i), obs_q[i].data, exp_q[i].data);
      end
      $display("frame %s: %0d writes observed, %0d expected", name, obs_q.size(), exp_q.size());
   endtask

   function automatic int first_cyc();
      return (obs_q.size() > 0) ? obs_q[0].cyc : -1;
   endfunction

   function automatic int last_cyc();
      return (obs_q.size() > 0) ? obs_q[obs_q.size()-1].cyc : -1;
   endfunction

   initial begin
      bus.in_valid = 1'b0;
      bus.in_node  = '0;
      bus.in_last  = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.in_ready", bus.in_ready, 0);
      check("reset.strobes", {bus.conf_nodes, bus.mem_weight, bus.mem_rew, bus.mem_act, bus.mem_par}, 0);
      check("reset.mem_addr", bus.mem_addr, 0);
      check("reset.mem_data", bus.mem_data, 0);
      check("reset.conf_data", bus.conf_data, 0);
      check("reset.busy", bus.busy, 0);
      check("reset.overflow", bus.overflow_err, 0);
      rst = 1'b0;
      #1;
      check("reset.in_ready_after", bus.in_ready, 1);
      @(negedge clk);

      // Single-node frame with hand-decoded fields
      obs_q.delete(); exp_q.delete();
      push(32'h003F_FF8A, 1'b1);
      wait_idle("single");
      exp_q.push_back('{0, 0, 0, 'h000});
      exp_q.push_back('{0, 1, 0, 'h007});
      exp_q.push_back('{0, 2, 0, 'hFFF});
      exp_q.push_back('{0, 3, 0, 'h00A});
      exp_q.push_back('{0, 4, -1, 1});
      compare_events("single");
      check("single.par_latency", first_cyc(), acc_edge + 1);
      check("single.busy_drop", idle_cyc, last_cyc() + 1);

      // Three nodes streamed back to back
      obs_q.delete(); exp_q.delete();
      w0 = 32'hFFC0_0001; w1 = 32'h0028_0C7F; w2 = 32'h8014_8055;
      push(w0, 1'b0); push(w1, 1'b0); push(w2, 1'b1);
      wait_idle("stream3");
      exp_node(0, w0); exp_node(1, w1); exp_node(2, w2); exp_conf(3);
      compare_events("stream3");
      check("stream3.no_gaps", last_cyc() - first_cyc(), 12);

      // Backpressure: eight nodes offered every cycle
      obs_q.delete(); exp_q.delete();
      stall_seen = 0; stall_at = -1; accepted = 0;
      for (int i = 0; i < 8; i++) push(mk(i + 100), i == 7);
      wait_idle("backpressure");
      for (int i = 0; i < 8; i++) exp_node(i, mk(i + 100));
      exp_conf(8);
      compare_events("backpressure");
      check("backpressure.accepted_before_stall", stall_at, 5);

      // Reset asserted during ACT of node 1
      obs_q.delete(); exp_q.delete();
      w0 = mk(7); w1 = mk(8);
      push(w0, 1'b0); push(w1, 1'b1);
      for (int n = 0; n < 100 && !(bus.mem_act && bus.mem_addr == 1); n++) @(negedge clk);
      check("midrst.act1_reached", bus.mem_act && bus.mem_addr == 1, 1);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check("midrst.busy", bus.busy, 0);
      exp_node(0, w0);
      exp_q.push_back('{0, 0, 1, int'(w1[31:22])});
      exp_q.push_back('{0, 1, 1, int'(w1[21:19])});
      compare_events("midrst");
      obs_q.delete(); exp_q.delete();
      w0 = mk(21); w1 = mk(22);
      push(w0, 1'b0); push(w1, 1'b1);
      wait_idle("after_rst");
      exp_node(0, w0); exp_node(1, w1); exp_conf(2);
      compare_events("after_rst");

      // Two frames back to back (2 then 1 nodes)
      obs_q.delete(); exp_q.delete();
      w0 = mk(300); w1 = mk(301); w2 = mk(302);
      push(w0, 1'b0); push(w1, 1'b1); push(w2, 1'b1);
      wait_idle("b2b");
      exp_node(0, w0); exp_node(1, w1); exp_conf(2); exp_node(0, w2); exp_conf(1);
      compare_events("b2b");
      check("b2b.no_gaps", last_cyc() - first_cyc(), 13);

      // Overflow: 1025-node frame
      check("overflow.clear_before", bus.overflow_err, 0);
      obs_q.delete(); exp_q.delete();
      for (int i = 0; i < 1025; i++) push(mk(i), i == 1024);
      wait_idle("overflow");
      for (int i = 0; i < 1023; i++) exp_node(i, mk(i));
      exp_conf(1023);
      compare_events("overflow");
      check("overflow.sticky", bus.overflow_err, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
